// File: rtl/router_fifo_16x9.sv
// rtl/router_fifo_16x9.sv - 16x9 router output FIFO with header-tagged packet length tracking; ROUTER_FIFO_HIZ_EN tri-states idle data_out
module router_fifo_16x9 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              soft_reset,
    input  logic              lfd_state,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] data_out
);

    // Each word is {header tag, data byte}
    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [6:0]        fifo_down_counter;
    logic              lfd_state_temp;
    logic [DATA_W-1:0] out_reg;
    logic              out_en;
    logic              do_write;
    logic              do_read;
    logic [DATA_W:0]   rd_word;
    logic              unused_debug;

    // Pointer MSB toggles once per lap, so equal low bits mean full or empty
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_write = write_enb && !full;
    assign do_read  = read_enb && !empty;
    assign rd_word  = mem[rd_ptr[ADDR_W-1:0]];

    // lfd_state_temp is a debug copy with no consumer inside the block
    assign unused_debug = lfd_state_temp;

    // Storage and pointers; flushes clear every word so stale tags never reappear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
                wr_ptr                  <= wr_ptr + (ADDR_W+1)'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end
        end
    end

    // Registered readout; header reads load payload length plus one for parity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg           <= '0;
            out_en            <= 1'b1;
            fifo_down_counter <= '0;
        end else if (soft_reset) begin
            out_reg           <= '0;
            out_en            <= 1'b0;
            fifo_down_counter <= '0;
        end else if (do_read) begin
            out_reg <= rd_word[DATA_W-1:0];
            out_en  <= 1'b1;
            if (rd_word[DATA_W]) begin
                fifo_down_counter <= 7'(rd_word[DATA_W-1:2]) + 7'd1;
            end else if (fifo_down_counter != 7'd0) begin
                fifo_down_counter <= fifo_down_counter - 7'd1;
            end
        end else if (fifo_down_counter == 7'd0) begin
            out_reg <= '0;
            out_en  <= 1'b0;
        end
    end

    // Debug copy of the header strobe, sampled every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfd_state_temp <= 1'b0;
        end else begin
            lfd_state_temp <= lfd_state;
        end
    end

`ifdef ROUTER_FIFO_HIZ_EN
    assign data_out = out_en ? out_reg : {DATA_W{1'bz}};
`else
    assign data_out = out_en ? out_reg : '0;
`endif

endmodule

// File: tb/tb_router_fifo_16x9.sv
// tb/tb_router_fifo_16x9.sv - directed table-driven bench for router_fifo_16x9
module tb_router_fifo_16x9;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       soft_reset = 1'b0;
    logic       lfd_state = 1'b0;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

`ifdef ROUTER_FIFO_HIZ_EN
    localparam logic [7:0] IDLE = 8'bzzzz_zzzz;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    typedef struct {
        logic       wr;
        logic       rd;
        logic       lfd;
        logic [7:0] din;
        logic       e_empty;
        logic       e_full;
        logic       e_idle;
        logic [7:0] e_dout;
        logic [6:0] e_cnt;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] pl[10];

    router_fifo_16x9 dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .soft_reset (soft_reset),
        .lfd_state  (lfd_state),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic wr, logic rd, logic lfd, logic [7:0] din,
                                logic e_empty, logic e_full, logic e_idle,
                                logic [7:0] e_dout, logic [6:0] e_cnt);
        vec_t v;
        v.wr = wr; v.rd = rd; v.lfd = lfd; v.din = din;
        v.e_empty = e_empty; v.e_full = e_full; v.e_idle = e_idle;
        v.e_dout = e_dout; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic lfd, input logic [7:0] din);
        write_enb = wr;
        read_enb  = rd;
        lfd_state = lfd;
        data_in   = din;
    endtask

    initial begin
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

        // Packet 1: header 0x29 (length 10), payload, parity 0x40
        tbl.push_back(mk(1, 0, 1, 8'h29, 0, 0, 1, 8'h00, 7'd0));
        for (int k = 0; k < 10; k++) tbl.push_back(mk(1, 0, 0, pl[k], 0, 0, 1, 8'h00, 7'd0));
        tbl.push_back(mk(1, 0, 0, 8'h40, 0, 0, 1, 8'h00, 7'd0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h29, 7'd11));
        for (int k = 0; k < 10; k++) tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, pl[k], 7'(10 - k)));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 8'h40, 7'd0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h00, 7'd0));
        // Zero-length header 0x03 still delivers its parity byte
        tbl.push_back(mk(1, 0, 1, 8'h03, 0, 0, 1, 8'h00, 7'd0));
        tbl.push_back(mk(1, 0, 0, 8'h55, 0, 0, 1, 8'h00, 7'd0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h03, 7'd1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 8'h55, 7'd0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 7'd0));

        // Power-on reset
        #2 reset = 1'b1;
        #1;
        chk("por_empty", 32'(empty), 32'd1);
        chk("por_full", 32'(full), 32'd0);
        chk("por_dout", 32'(data_out), 32'h00);
        chk("por_cnt", 32'(dut.fifo_down_counter), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Table-driven packets
        foreach (tbl[i]) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].lfd, tbl[i].din);
            step();
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].e_idle ? IDLE : tbl[i].e_dout));
            chk($sformatf("tbl%0d_cnt", i), 32'(dut.fifo_down_counter), 32'(tbl[i].e_cnt));
        end
        drive(0, 0, 0, 8'h00);

        // Fill with 17 bytes; the 17th is dropped
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 0, 8'(8'hB0 + i));
            step();
            chk($sformatf("fill%0d_full", i), 32'(full), 32'(i >= 15));
            chk($sformatf("fill%0d_empty", i), 32'(empty), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 8'h00);
            step();
            chk($sformatf("drain%0d_dout", i), 32'(data_out), 32'(8'hB0 + i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full", 32'(full), 32'd0);
        drive(0, 0, 0, 8'h00);
        step();

        // Simultaneous read and write while full
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 8'(8'hC0 + i));
            step();
        end
        chk("refill_full", 32'(full), 32'd1);
        drive(1, 1, 0, 8'hEE);
        step();
        chk("rw_dout", 32'(data_out), 32'hC0);
        chk("rw_full_after", 32'(full), 32'd0);
        drive(1, 0, 0, 8'hEE);
        step();
        chk("rewrite_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 8'h00);
            step();
            chk($sformatf("rwdrain%0d_dout", i), 32'(data_out), 32'(i < 15 ? 8'(8'hC1 + i) : 8'hEE));
        end
        chk("rwdrain_empty", 32'(empty), 32'd1);
        drive(0, 0, 0, 8'h00);
        step();

        // Soft reset in mid-packet
        drive(1, 0, 1, 8'h1A);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 8'(8'h01 + i));
            step();
        end
        drive(1, 0, 0, 8'h20);
        step();
        drive(0, 1, 0, 8'h00);
        step();
        chk("p2_hdr_dout", 32'(data_out), 32'h1A);
        chk("p2_hdr_cnt", 32'(dut.fifo_down_counter), 32'd7);
        step();
        chk("p2_b1_cnt", 32'(dut.fifo_down_counter), 32'd6);
        step();
        chk("p2_b2_dout", 32'(data_out), 32'h02);
        chk("p2_b2_cnt", 32'(dut.fifo_down_counter), 32'd5);
        drive(1, 1, 0, 8'h77);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        chk("srst_empty", 32'(empty), 32'd1);
        chk("srst_full", 32'(full), 32'd0);
        chk("srst_cnt", 32'(dut.fifo_down_counter), 32'd0);
        chk("srst_dout", 32'(data_out), 32'(IDLE));
        drive(0, 1, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("post_srst%0d_dout", i), 32'(data_out), 32'(IDLE));
            chk($sformatf("post_srst%0d_empty", i), 32'(empty), 32'd1);
        end
        drive(0, 0, 0, 8'h00);

        // Asynchronous reset with 5 entries written and one header read out
        drive(1, 0, 1, 8'h29);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 8'(8'h10 + i));
            step();
        end
        drive(0, 1, 0, 8'h00);
        step();
        drive(0, 0, 0, 8'h00);
        chk("pre_arst_dout", 32'(data_out), 32'h29);
        chk("pre_arst_cnt", 32'(dut.fifo_down_counter), 32'd11);
        chk("pre_arst_empty", 32'(empty), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_dout", 32'(data_out), 32'h00);
        chk("arst_cnt", 32'(dut.fifo_down_counter), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("after_arst_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
